// File: rtl/dram_line_master.sv
// dram_line_master: splits whole-line read/write requests into back-to-back DRAM word beats
// and assembles the one-cycle-delayed read data into a line response.
module dram_line_master #(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  parameter int line_words_p = 8,
  localparam int num_data_bytes_lp = data_width_p / 8,
  localparam int line_width_lp = data_width_p * line_words_p,
  localparam int line_bytes_lp = num_data_bytes_lp * line_words_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_v_i,
  output logic                         req_ready_o,
  input  logic                         req_w_i,
  input  logic [addr_width_p-1:0]      req_addr_i,
  input  logic [line_width_lp-1:0]     req_data_i,
  input  logic [line_bytes_lp-1:0]     req_mask_i,
  output logic                         resp_v_o,
  input  logic                         resp_ready_i,
  output logic                         resp_w_o,
  output logic [line_width_lp-1:0]     resp_data_o,
  output logic                         dram_v_o,
  output logic                         dram_w_o,
  output logic [addr_width_p-1:0]      dram_addr_o,
  output logic [data_width_p-1:0]      dram_data_o,
  output logic [num_data_bytes_lp-1:0] dram_write_mask_o,
  input  logic [data_width_p-1:0]      dram_data_i
);
  localparam int cnt_w_lp = $clog2(line_words_p);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_e;
  state_e state_r;
  logic [cnt_w_lp-1:0] k_r, k_next, k_prev;
  logic [line_width_lp-1:0] data_r;
  logic [line_bytes_lp-1:0] mask_r;
  logic last_beat;
  assign k_next = k_r + 1'b1;
  assign k_prev = k_r - 1'b1;
  assign last_beat = k_r == cnt_w_lp'(line_words_p - 1);
  assign req_ready_o = state_r == IDLE;
  // The first beat is loaded at the accepting edge so beats start the very next cycle.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= IDLE;
      k_r <= '0;
      data_r <= '0;
      mask_r <= '0;
      resp_v_o <= 1'b0;
      resp_w_o <= 1'b0;
      resp_data_o <= '0;
      dram_v_o <= 1'b0;
      dram_w_o <= 1'b0;
      dram_addr_o <= '0;
      dram_data_o <= '0;
      dram_write_mask_o <= '0;
    end else begin
      case (state_r)
        IDLE: if (req_v_i && req_ready_o) begin
          state_r <= req_w_i ? WRITE : READ;
          k_r <= '0;
          data_r <= req_data_i;
          mask_r <= req_mask_i;
          resp_w_o <= req_w_i;
          dram_v_o <= 1'b1;
          dram_w_o <= req_w_i;
          dram_addr_o <= req_addr_i & ~addr_width_p'(line_bytes_lp - 1);
          dram_data_o <= req_w_i ? req_data_i[data_width_p-1:0] : '0;
          dram_write_mask_o <= req_w_i ? req_mask_i[num_data_bytes_lp-1:0] : '0;
        end
        WRITE, READ: begin
          // Read data lags its beat by one cycle, so beat k delivers word k-1.
          if (state_r == READ && k_r != '0)
            resp_data_o[k_prev*data_width_p +: data_width_p] <= dram_data_i;
          if (last_beat) begin
            state_r <= (state_r == WRITE) ? RESP : DRAIN;
            resp_v_o <= state_r == WRITE;
            dram_v_o <= 1'b0;
            dram_w_o <= 1'b0;
            dram_data_o <= '0;
            dram_write_mask_o <= '0;
          end else begin
            k_r <= k_next;
            dram_addr_o <= dram_addr_o + addr_width_p'(num_data_bytes_lp);
            dram_data_o <= (state_r == WRITE) ? data_r[k_next*data_width_p +: data_width_p] : '0;
            dram_write_mask_o <= (state_r == WRITE) ? mask_r[k_next*num_data_bytes_lp +: num_data_bytes_lp] : '0;
          end
        end
        DRAIN: begin
          resp_data_o[line_width_lp-1 -: data_width_p] <= dram_data_i;
          resp_v_o <= 1'b1;
          state_r <= RESP;
        end
        RESP: if (resp_ready_i) begin
          resp_v_o <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_line_master.sv
// tb_dram_line_master: directed line requests against a byte-addressed DRAM model,
// with a scoreboard queue checked by an independent response monitor.
module tb_dram_line_master;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic req_v_i = 1'b0, req_ready_o, req_w_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [511:0] req_data_i = '0;
  logic [63:0] req_mask_i = '0;
  logic resp_v_o, resp_ready_i = 1'b1, resp_w_o;
  logic [511:0] resp_data_o;
  logic dram_v_o, dram_w_o;
  logic [31:0] dram_addr_o;
  logic [63:0] dram_data_o, dram_data_i;
  logic [7:0] dram_write_mask_o;
  logic [63:0] rd_data = '0;
  logic [7:0] mem [logic [31:0]];
  typedef struct {logic w; logic [511:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [511:0] last_read = '0;
  logic [511:0] line1, line_a5, line_ff, line_part, line_wr;
  int checks = 0, failures = 0;

  dram_line_master dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_w_o(resp_w_o),
    .resp_data_o(resp_data_o),
    .dram_v_o(dram_v_o), .dram_w_o(dram_w_o), .dram_addr_o(dram_addr_o),
    .dram_data_o(dram_data_o), .dram_write_mask_o(dram_write_mask_o),
    .dram_data_i(dram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // DRAM model: registered read, unwritten bytes read as zero.
  always @(posedge clk_i)
    if (dram_v_o) begin
      if (dram_w_o) begin
        for (int b = 0; b < 8; b++)
          if (dram_write_mask_o[b]) mem[dram_addr_o + 32'(b)] = dram_data_o[8*b +: 8];
      end else begin
        for (int b = 0; b < 8; b++)
          rd_data[8*b +: 8] <= mem.exists(dram_addr_o + 32'(b)) ? mem[dram_addr_o + 32'(b)] : 8'h00;
      end
    end
  assign dram_data_i = rd_data;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i)
    if (!reset_i && resp_v_o && resp_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_resp: got response with data %h, expected none", resp_data_o);
      end else begin
        mon_e = sb.pop_front();
        check("resp_w", 512'(resp_w_o), 512'(mon_e.w));
        check("resp_data", resp_data_o, mon_e.data);
      end
    end

  // Caller must be at a negedge; returns at the negedge after the response handshake.
  task automatic do_req(input logic w, input logic [31:0] addr, input logic [511:0] data,
                        input logic [63:0] mask, input logic [511:0] exp_data,
                        input logic [31:0] exp_base, input int hold);
    int c, lat;
    bit seen;
    exp_t e;
    c = 0;
    while (!req_ready_o && c < 20) begin
      @(negedge clk_i);
      c++;
    end
    check("req_ready_idle", 512'(req_ready_o), 512'(1));
    req_v_i = 1'b1; req_w_i = w; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
    @(posedge clk_i);
    e.w = w;
    e.data = w ? last_read : exp_data;
    sb.push_back(e);
    if (!w) last_read = exp_data;
    #1;
    req_v_i = 1'b0; req_w_i = ~w; req_addr_i = ~addr; req_data_i = ~data; req_mask_i = ~mask;
    if (hold > 0) resp_ready_i = 1'b0;
    lat = w ? 9 : 10;
    seen = 0;
    for (c = 1; c <= 30 && !seen; c++) begin
      @(negedge clk_i);
      if (c <= 8) begin
        check("beat_v", 512'(dram_v_o), 512'(1));
        check("beat_w", 512'(dram_w_o), 512'(w));
        check("beat_addr", 512'(dram_addr_o), 512'(exp_base + 32'(8*(c-1))));
        if (w) begin
          check("beat_data", 512'(dram_data_o), 512'(data[64*(c-1) +: 64]));
          check("beat_mask", 512'(dram_write_mask_o), 512'(mask[8*(c-1) +: 8]));
        end
      end else begin
        check("post_dram_v", 512'(dram_v_o), 512'(0));
        check("post_dram_w", 512'(dram_w_o), 512'(0));
      end
      if (resp_v_o) begin
        seen = 1;
        check("resp_latency", 512'(c), 512'(lat));
      end else
        check("busy_ready", 512'(req_ready_o), 512'(0));
    end
    if (!seen) check("resp_timeout", 512'(resp_v_o), 512'(1));
    if (seen && hold > 0) begin
      repeat (hold) begin
        check("hold_resp_v", 512'(resp_v_o), 512'(1));
        check("hold_resp_data", resp_data_o, e.data);
        check("hold_req_ready", 512'(req_ready_o), 512'(0));
        check("hold_dram_v", 512'(dram_v_o), 512'(0));
        @(posedge clk_i);
      end
      #1 resp_ready_i = 1'b1;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    check("spacing_ready", 512'(req_ready_o), 512'(1));
    check("spacing_resp_v", 512'(resp_v_o), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      line1[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
      line_wr[64*k +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
    end
    line_a5 = {64{8'hA5}};
    line_ff = {64{8'hFF}};
    line_part = line_a5;
    line_part[63:0] = 64'hA5A5A5A5_FFFFFFFF;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_req_ready", 512'(req_ready_o), 512'(1));
    check("rst_resp_v", 512'(resp_v_o), 512'(0));
    check("rst_resp_w", 512'(resp_w_o), 512'(0));
    check("rst_resp_data", resp_data_o, 512'(0));
    check("rst_dram_v", 512'(dram_v_o), 512'(0));
    check("rst_dram_w", 512'(dram_w_o), 512'(0));
    check("rst_dram_addr", 512'(dram_addr_o), 512'(0));
    check("rst_dram_data", 512'(dram_data_o), 512'(0));
    check("rst_dram_mask", 512'(dram_write_mask_o), 512'(0));
    do_req(1'b1, 32'h1000, line1, '1, '0, 32'h1000, 0);
    do_req(1'b0, 32'h1000, '0, '0, line1, 32'h1000, 0);
    do_req(1'b1, 32'h2000, line_a5, '1, '0, 32'h2000, 0);
    do_req(1'b1, 32'h2000, line_ff, 64'h0F, '0, 32'h2000, 0);
    do_req(1'b0, 32'h203C, '0, '0, line_part, 32'h2000, 0);
    do_req(1'b0, 32'h2000, '0, '0, line_part, 32'h2000, 5);
    do_req(1'b1, 32'hFFFF_FFC0, line_wr, '1, '0, 32'hFFFF_FFC0, 0);
    do_req(1'b0, 32'h0, '0, '0, 512'(0), 32'h0, 0);
    do_req(1'b0, 32'hFFFF_FFC0, '0, '0, line_wr, 32'hFFFF_FFC0, 0);
    // Abort a read in its third beat with an asynchronous reset.
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 32'h1000;
    @(posedge clk_i);
    #1 req_v_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("abort_beat_v", 512'(dram_v_o), 512'(1));
    #2 reset_i = 1'b1;
    #1;
    check("abort_dram_v", 512'(dram_v_o), 512'(0));
    check("abort_resp_v", 512'(resp_v_o), 512'(0));
    check("abort_req_ready", 512'(req_ready_o), 512'(1));
    check("abort_dram_addr", 512'(dram_addr_o), 512'(0));
    check("abort_resp_data", resp_data_o, 512'(0));
    last_read = '0;
    @(negedge clk_i);
    reset_i = 1'b0;
    do_req(1'b0, 32'h1000, '0, '0, line1, 32'h1000, 0);
    repeat (2) @(negedge clk_i);
    check("sb_drained", 512'(sb.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_line_master.md
# dram_line_master

Bus initiator that drives the single-port, byte-addressed simulation DRAM model's request interface on behalf of a cache-line client. It accepts one whole-line read or write request on a valid/ready handshake and splits it into `line_words_p` consecutive word beats. For reads it captures the DRAM's one-cycle-delayed read data and returns the assembled line on a valid/ready response port. It sits between the L2/LLC refill/writeback path and the DRAM model in the testbench.

## Interface
- `data_width_p`, 64, DRAM word width in bits; a multiple of 8.
- `addr_width_p`, 32, byte address width.
- `line_words_p`, 8, words per line; a power of 2, ≥2.
- Derived values:
  - `num_data_bytes_lp` = `data_width_p`/8.
  - `line_width_lp` = `data_width_p`*`line_words_p`.
  - `line_bytes_lp` = `num_data_bytes_lp`*`line_words_p`.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_v_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_w_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in `addr_width_p`: line byte address; the low log2(`line_bytes_lp`) bits are ignored (treated as 0).
- `req_data_i` in `line_width_lp`: write line; word k = bits [k*`data_width_p` +: `data_width_p`].
- `req_mask_i` in `line_bytes_lp`: byte enables; bit k*`num_data_bytes_lp`+b enables byte b of word k.
- `resp_v_o` out 1: response valid.
- `resp_ready_i` in 1: response ready.
- `resp_w_o` out 1: echoes the request type.
- `resp_data_o` out `line_width_lp`: read line.
- `dram_v_o` out 1: DRAM request valid.
- `dram_w_o` out 1: DRAM write enable.
- `dram_addr_o` out `addr_width_p`: DRAM byte address.
- `dram_data_o` out `data_width_p`: DRAM write data.
- `dram_write_mask_o` out `num_data_bytes_lp`: DRAM byte write mask.
- `dram_data_i` in `data_width_p`: DRAM read data (combinational from the DRAM's registered read address).

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, RESP.
- **IDLE:**
  - `req_ready_o`=1.
  - On `req_v_i`&`req_ready_o` (this is the only handshake), register type, aligned base, data and mask, and clear the beat counter.
  - Go to WRITE if `req_w_i`=1, else READ.
- **WRITE:**
  - Each cycle: `dram_v_o`=1, `dram_w_o`=1, `dram_addr_o`=base+k*`num_data_bytes_lp`, `dram_data_o`=word k, `dram_write_mask_o`=mask slice k.
  - k increments every cycle.
  - A beat whose mask is all zero is still issued, so latency is fixed.
  - After beat `line_words_p`-1, go to RESP.
- **READ:**
  - Each cycle issue a read beat k: `dram_v_o`=1, `dram_w_o`=0, address as in WRITE.
  - From the second READ cycle on, capture `dram_data_i` into `resp_data_o` word k-1 at the clock edge.
  - After beat `line_words_p`-1, go to DRAIN.
- **DRAIN:**
  - `dram_v_o`=0.
  - Capture `dram_data_i` into word `line_words_p`-1, then go to RESP.
- **RESP:**
  - `resp_v_o`=1, `resp_w_o`=registered type.
  - Hold all response outputs stable until `resp_ready_i`; on that edge go to IDLE.
- **Outputs outside the active states:**
  - In RESP and IDLE, `dram_v_o`=0; `dram_w_o`, `dram_data_o` and `dram_write_mask_o` are 0.
  - `dram_addr_o` holds its last value.
- **`resp_data_o` rules:**
  - Updated only by read captures.
  - A write response leaves it holding the previous read line.
- **Address arithmetic:** modulo 2^`addr_width_p`; a line at the top of the address space wraps to 0 without error.
- **Reset mid-operation:**
  - Immediately forces IDLE and the reset values below.
  - Beats already written stay in DRAM; no response is generated for the aborted request.
- **Reset values:** `req_ready_o`=1 (IDLE), `resp_v_o`=0, `resp_w_o`=0, `resp_data_o`=0, `dram_v_o`=0, `dram_w_o`=0, `dram_addr_o`=0, `dram_data_o`=0, `dram_write_mask_o`=0.

## Timing
- Request handshake in cycle 0; first DRAM beat in cycle 1; beats are back-to-back with no bubbles.
- **Read:**
  - Beats in cycles 1..L (L = `line_words_p`).
  - Word k is captured at the end of cycle k+2.
  - `resp_v_o` rises in cycle L+2.
- **Write:**
  - Beats in cycles 1..L.
  - `resp_v_o` rises in cycle L+1.
- Minimum spacing is one idle cycle: the response handshake in cycle R allows `req_ready_o`=1 in cycle R+1.
- `req_ready_o` is 0 in every non-IDLE state.
- Request inputs are sampled only at the accepting edge.

## Test plan
- **Full-line write, then read:**
  - Stimulus (L=8): write addr 0x1000, word k = 0x1111_1111_1111_1111*k, mask all ones; then read 0x1000.
  - Required response:
    - DRAM addrs 0x1000, 0x1008 … 0x1038.
    - Write `resp_v_o` in cycle 9.
    - Read `resp_v_o` in cycle 10 with identical data.
- **Partial mask:**
  - Stimulus: write 0xA5 to every byte of line 0x2000; then write 0xFF bytes with mask 0x...0F only (word 0 bytes 0-3); then read.
  - Required response: word 0 = 0xA5A5A5A5_FFFFFFFF; all other words = 0xA5 bytes.
- **Unaligned request address:**
  - Stimulus: read 0x203C.
  - Required response: beats start at 0x2000.
- **Response backpressure:**
  - Stimulus: hold `resp_ready_i`=0 for 5 cycles.
  - Required response: `resp_v_o` and `resp_data_o` stable; `req_ready_o`=0; `dram_v_o`=0 throughout.
- **Wrap:**
  - Stimulus: `addr_width_p`=32, write line 0xFFFF_FFC0.
  - Required response: last beat addr 0xFFFF_FFF8; no X; next line at 0x0 unchanged.
- **Async reset:**
  - Stimulus: assert `reset_i` during read beat 3, mid-cycle.
  - Required response: `dram_v_o`=0 and `resp_v_o`=0 immediately; `req_ready_o`=1; a subsequent read completes normally.
